mem_access: RTL and testbench

Memory-access stage: the consumer end of the load/store request the execute stage produces (memory op code, effective address, store data, destination register). It runs each load or store as a byte-serial sequence on an 8-bit synchronous RAM port, assembles and sign/zero-extends load data, and holds the pipeline with a stall request until the access completes. Non-memory instructions pass through with one register stage.

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_access_load_ext.sv | 21 ++
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states and
// op-decoding helpers used by mem_access and load_ext.
package mem_access_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ME_NOP_OP = 4'd0;
  localparam logic [ALU_OP_W-1:0] ME_LB_OP  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ME_LH_OP  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ME_LW_OP  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ME_LBU_OP = 4'd4;
  localparam logic [ALU_OP_W-1:0] ME_LHU_OP = 4'd5;
  localparam logic [ALU_OP_W-1:0] ME_SB_OP  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ME_SH_OP  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ME_SW_OP  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bytes moved by an op; 0 means "not a memory op".
  function automatic logic [2:0] op_nbytes(input logic [ALU_OP_W-1:0] op);
    case (op)
      ME_LB_OP, ME_LBU_OP, ME_SB_OP: op_nbytes = 3'd1;
      ME_LH_OP, ME_LHU_OP, ME_SH_OP: op_nbytes = 3'd2;
      ME_LW_OP, ME_SW_OP:            op_nbytes = 3'd4;
      default:                       op_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [ALU_OP_W-1:0] op);
    case (op)
      ME_LB_OP, ME_LH_OP, ME_LW_OP, ME_LBU_OP, ME_LHU_OP: op_is_load = 1'b1;
      default:                                            op_is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext: size and sign/zero extension of the assembled little-endian load word.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [31:0]         raw_i,
  output logic [31:0]         data_o
);

  always_comb begin
    data_o = raw_i;
    case (op_i)
      ME_LB_OP:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      ME_LBU_OP: data_o = {24'd0, raw_i[7:0]};
      ME_LH_OP:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      ME_LHU_OP: data_o = {16'd0, raw_i[15:0]};
      default:   data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: byte-serial load/store stage on an 8-bit synchronous RAM port.
// Optional MEM_MISALIGN_CHK_EN rejects unaligned halfword/word accesses.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic [ALU_OP_W-1:0] aluop_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         sdata_i,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic [31:0]         wdata_i,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [31:0]         wdata_o,
  output logic                done_o,
  output logic                stall_req_o,
  output logic                misalign_o,
  output logic [ADDR_W-1:0]   ram_a_o,
  output logic [7:0]          ram_dout_o,
  output logic                ram_wr_o,
  input  logic [7:0]          ram_din_i
);

  state_e              state_q, state_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         sdata_q, sdata_d;
  logic [4:0]          wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic [31:0]         lane_q, lane_d;
  logic                mis_q, mis_d;
  logic                done_q, done_d;
  logic [4:0]          wd_o_q, wd_o_d;
  logic                wreg_o_q, wreg_o_d;
  logic [31:0]         wdata_o_q, wdata_o_d;
  logic                misalign_q, misalign_d;

  logic                in_mem_s;
  logic [2:0]          in_nbytes_s;
  logic                in_mis_s;
  logic                is_load_s;
  logic [1:0]          cap_idx_s;
  logic [31:0]         ext_s;

  load_ext u_load_ext (
    .op_i  (op_q),
    .raw_i (lane_q),
    .data_o(ext_s)
  );

  assign in_nbytes_s = op_nbytes(aluop_i);
  assign in_mem_s    = (in_nbytes_s != 3'd0);
  assign is_load_s   = op_is_load(op_q);

`ifdef MEM_MISALIGN_CHK_EN
  assign in_mis_s = ((in_nbytes_s == 3'd2) && mem_addr_i[0]) ||
                    ((in_nbytes_s == 3'd4) && (mem_addr_i[1:0] != 2'd0));
`else
  assign in_mis_s = 1'b0;
`endif

  // RAM port and stall are decoded from the registered FSM state.
  assign ram_wr_o    = (state_q == ST_ISSUE) && !is_load_s;
  assign ram_a_o     = (state_q == ST_ISSUE) ? (addr_q + {{(ADDR_W-2){1'b0}}, idx_q})
                                             : {ADDR_W{1'b0}};
  assign ram_dout_o  = ram_wr_o ? sdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign stall_req_o = ((state_q == ST_IDLE) && req_i && in_mem_s) ||
                       (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign done_o     = done_q;
  assign wd_o       = wd_o_q;
  assign wreg_o     = wreg_o_q;
  assign wdata_o    = wdata_o_q;
  assign misalign_o = misalign_q;

  // Next-state, byte-lane capture and output staging.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    last_d     = last_q;
    lane_d     = lane_q;
    mis_d      = mis_q;
    done_d     = 1'b0;
    wd_o_d     = wd_o_q;
    wreg_o_d   = wreg_o_q;
    wdata_o_d  = wdata_o_q;
    misalign_d = misalign_q;
    cap_idx_s  = (state_q == ST_WAIT) ? last_q : (idx_q - 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          op_d    = in_mem_s ? aluop_i : ME_NOP_OP;
          addr_d  = mem_addr_i[ADDR_W-1:0];
          sdata_d = sdata_i;
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
          idx_d   = 2'd0;
          last_d  = 2'(in_nbytes_s - 3'd1);
          lane_d  = 32'd0;
          mis_d   = in_mis_s;
          state_d = (in_mem_s && !in_mis_s) ? ST_ISSUE : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Read data lags the address by one cycle, so capture the previous lane.
        if (is_load_s && (idx_q != 2'd0)) begin
          lane_d[{cap_idx_s, 3'b000} +: 8] = ram_din_i;
        end else begin
          lane_d = lane_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_q) begin
          state_d = is_load_s ? ST_WAIT : ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        lane_d[{cap_idx_s, 3'b000} +: 8] = ram_din_i;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        wd_o_d     = wd_q;
        misalign_d = mis_q;
        if (op_q == ME_NOP_OP) begin
          wreg_o_d  = wreg_q;
          wdata_o_d = wdata_q;
        end else if (is_load_s && !mis_q) begin
          wreg_o_d  = wreg_q && (wd_q != 5'd0);
          wdata_o_d = ext_s;
        end else begin
          wreg_o_d  = 1'b0;
          wdata_o_d = 32'd0;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= ME_NOP_OP;
      addr_q     <= {ADDR_W{1'b0}};
      sdata_q    <= 32'd0;
      wd_q       <= 5'd0;
      wreg_q     <= 1'b0;
      wdata_q    <= 32'd0;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      lane_q     <= 32'd0;
      mis_q      <= 1'b0;
      done_q     <= 1'b0;
      wd_o_q     <= 5'd0;
      wreg_o_q   <= 1'b0;
      wdata_o_q  <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      lane_q     <= lane_d;
      mis_q      <= mis_d;
      done_q     <= done_d;
      wd_o_q     <= wd_o_d;
      wreg_o_q   <= wreg_o_d;
      wdata_o_q  <= wdata_o_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: behavioural byte RAM, reference memory
// model and randomized load/store/NOP traffic plus directed corner cases.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [3:0]  aluop_i;
  logic [31:0] mem_addr_i, sdata_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        done_o, stall_req_o, misalign_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i = 8'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .sdata_i(sdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .done_o(done_o), .stall_req_o(stall_req_o), .misalign_o(misalign_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous byte RAM with one-cycle read latency; logs every write.
  always @(posedge clk) begin
    if (ram_wr_o) begin
      ram[ram_a_o] = ram_dout_o;
      wlog.push_back('{cyc, ram_a_o, ram_dout_o});
    end
    ram_din_i <= rd_ram(ram_a_o);
    cyc = cyc + 1;
  end

  function automatic int nb(input logic [3:0] op);
    case (op)
      ME_LB_OP, ME_LBU_OP, ME_SB_OP: return 1;
      ME_LH_OP, ME_LHU_OP, ME_SH_OP: return 2;
      ME_LW_OP, ME_SW_OP:            return 4;
      default:                       return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [3:0] op);
    return (op >= ME_LB_OP) && (op <= ME_LHU_OP);
  endfunction

  function automatic bit exp_mis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
    return (nb(op) == 2 && a[0]) || (nb(op) == 4 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nb(op); i++) v = v | (32'(rd_ref(a + 32'(i))) << (8 * i));
    if (op == ME_LB_OP && v[7])  v = v | 32'hFFFFFF00;
    if (op == ME_LH_OP && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a);
    if (nb(op) == 0 || exp_mis(op, a)) return 1;
    return is_ld(op) ? nb(op) + 2 : nb(op) + 1;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  // Drives one request and observes the DUT until done_o (bounded).
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                         output int lat, output int t0, output logic pre_st, output int st_hi,
                         output logic [4:0] owd, output logic owreg, output logic [31:0] owdata,
                         output logic omis, output logic ost);
    wlog.delete();
    @(negedge clk);
    req_i = 1'b1; aluop_i = op; mem_addr_i = a; sdata_i = sd;
    wd_i = wd; wreg_i = wr; wdata_i = wdat;
    #1 pre_st = stall_req_o;
    @(posedge clk); #1;
    t0 = cyc - 1;
    st_hi = int'(stall_req_o);
    lat = -1;
    @(negedge clk) req_i = 1'b0;
    if (done_o) lat = 0;
    else begin
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (done_o) begin lat = k; break; end
        st_hi += int'(stall_req_o);
      end
    end
    owd = wd_o; owreg = wreg_o; owdata = wdata_o; omis = misalign_o; ost = stall_req_o;
  endtask

  task automatic test_reset();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    rst = 1'b0; req_i = 1'b0; aluop_i = ME_NOP_OP; mem_addr_i = 32'd0; sdata_i = 32'd0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({done_o, stall_req_o, misalign_o, ram_wr_o, wreg_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", {done_o, stall_req_o, misalign_o, ram_wr_o, wreg_o}); end
    n_cmp++; if ({wd_o, wdata_o, ram_a_o, ram_dout_o} !== 77'd0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h required all 0", wd_o, wdata_o, ram_a_o, ram_dout_o); end
    @(negedge clk) rst = 1'b1;
    run_txn(ME_NOP_OP, 32'd0, 32'd0, 5'd9, 1'b1, 32'h12345678, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    // SW to 0x200 interrupted by reset after two bytes.
    @(negedge clk);
    wlog.delete();
    req_i = 1'b1; aluop_i = ME_SW_OP; mem_addr_i = 32'h200; sdata_i = 32'hAABBCCDD;
    @(posedge clk); #1;
    @(negedge clk) req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ram_wr_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre_wr: got %b required 1", ram_wr_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({ram_wr_o, stall_req_o, done_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_async: got wr/stall/done %b required 000", {ram_wr_o, stall_req_o, done_o}); end
    n_cmp++; if ({wd_o, wreg_o, wdata_o, ram_a_o} !== 70'd0) begin
      n_fail++; $display("FAIL rst_mid_outs: got %h/%b/%h/%h required all 0", wd_o, wreg_o, wdata_o, ram_a_o); end
    repeat (2) @(posedge clk);
    poke(32'h200, 8'hDD); ref_mem[32'h201] = 8'hCC;
    n_cmp++; if ({rd_ram(32'h200), rd_ram(32'h201), rd_ram(32'h202), rd_ram(32'h203)} !== 32'hDDCC0000) begin
      n_fail++; $display("FAIL rst_mid_ram: got %h%h%h%h required DDCC0000",
        rd_ram(32'h200), rd_ram(32'h201), rd_ram(32'h202), rd_ram(32'h203)); end
    n_cmp++; if (wlog.size() != 2) begin
      n_fail++; $display("FAIL rst_mid_wcount: got %0d required 2", wlog.size()); end
    @(negedge clk) rst = 1'b1;
    run_txn(ME_NOP_OP, 32'd0, 32'd0, 5'd1, 1'b0, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (lat != 1) begin
      n_fail++; $display("FAIL rst_idle_nop_lat: got %0d required 1", lat); end
  endtask

  task automatic test_store_sw();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    logic [31:0] sd = 32'h11223344;
    run_txn(ME_SW_OP, 32'h100, sd, 5'd3, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    for (int i = 0; i < 4; i++) ref_mem[32'h100 + 32'(i)] = sd[8*i +: 8];
    n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL sw_lat: got %0d required 5", lat); end
    n_cmp++; if ({owr, owdt} !== 33'd0) begin
      n_fail++; $display("FAIL sw_wb: got wreg %b wdata %h required 0/0", owr, owdt); end
    n_cmp++; if (wlog.size() != 4) begin n_fail++; $display("FAIL sw_wcount: got %0d required 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      n_cmp++;
      if (wlog[i].a !== 32'h100 + 32'(i) || wlog[i].d !== sd[8*i +: 8] || wlog[i].c != t0 + 1 + i) begin
        n_fail++; $display("FAIL sw_write[%0d]: got a=%h d=%h c=%0d required a=%h d=%h c=%0d",
          i, wlog[i].a, wlog[i].d, wlog[i].c, 32'h100 + 32'(i), sd[8*i +: 8], t0 + 1 + i); end
    end
  endtask

  task automatic test_loads();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    run_txn(ME_LW_OP, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (owdt !== 32'h11223344 || owr !== 1'b1 || owd !== 5'd7) begin
      n_fail++; $display("FAIL lw_data: got %h wreg %b wd %0d required 11223344 1 7", owdt, owr, owd); end
    n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL lw_lat: got %0d required 6", lat); end
    n_cmp++; if (!ps || sh != 5 || ost) begin
      n_fail++; $display("FAIL lw_stall: got pre %b high %0d at_done %b required 1 5 0", ps, sh, ost); end
    poke(32'h103, 8'h80);
    run_txn(ME_LB_OP, 32'h103, 32'h0, 5'd2, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (owdt !== 32'hFFFFFF80 || lat != 3) begin
      n_fail++; $display("FAIL lb_sext: got %h lat %0d required FFFFFF80 3", owdt, lat); end
    run_txn(ME_LBU_OP, 32'h103, 32'h0, 5'd2, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (owdt !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu_zext: got %h required 00000080", owdt); end
    run_txn(ME_LHU_OP, 32'h102, 32'h0, 5'd0, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (owdt !== 32'h00008022 || owr !== 1'b0 || lat != 4) begin
      n_fail++; $display("FAIL lhu_wd0: got %h wreg %b lat %0d required 00008022 0 4", owdt, owr, lat); end
  endtask

  task automatic test_nop();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    run_txn(ME_NOP_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, lat, t0, ps, sh, owd, owr, owdt, om, ost);
    n_cmp++; if (lat != 1 || owd !== 5'd5 || owr !== 1'b1 || owdt !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL nop_pass: got lat %0d wd %0d wreg %b wdata %h required 1 5 1 DEADBEEF", lat, owd, owr, owdt); end
    n_cmp++; if (ps || sh != 0 || ost) begin
      n_fail++; $display("FAIL nop_stall: got pre %b high %0d done %b required 0 0 0", ps, sh, ost); end
  endtask

  task automatic test_misalign();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    poke(32'h102, 8'hA5);
    run_txn(ME_LH_OP, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, lat, t0, ps, sh, owd, owr, owdt, om, ost);
`ifdef MEM_MISALIGN_CHK_EN
    n_cmp++; if (lat != 1 || om !== 1'b1 || owr !== 1'b0 || owdt !== 32'd0) begin
      n_fail++; $display("FAIL lh_misalign: got lat %0d mis %b wreg %b wdata %h required 1 1 0 0", lat, om, owr, owdt); end
`else
    n_cmp++; if (lat != 4 || om !== 1'b0 || owdt !== 32'hFFFFA533) begin
      n_fail++; $display("FAIL lh_unaligned: got lat %0d mis %b wdata %h required 4 0 FFFFA533", lat, om, owdt); end
`endif
  endtask

  task automatic test_wrap();
`ifndef MEM_MISALIGN_CHK_EN
    logic [31:0] exp_a [4];
    logic [31:0] ev;
    bit got = 1'b0;
    exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    poke(32'hFFFFFFFE, 8'h5A); poke(32'hFFFFFFFF, 8'hC3); poke(32'h0, 8'h7E); poke(32'h1, 8'h19);
    ev = exp_load(ME_LW_OP, 32'hFFFFFFFE);
    @(negedge clk);
    req_i = 1'b1; aluop_i = ME_LW_OP; mem_addr_i = 32'hFFFFFFFE;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) req_i = 1'b0;
      n_cmp++; if (ram_a_o !== exp_a[i] || ram_wr_o !== 1'b0) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %h wr %b required %h 0", i, ram_a_o, ram_wr_o, exp_a[i]); end
    end
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      got = done_o;
    end
    n_cmp++; if (!got || wdata_o !== ev) begin
      n_fail++; $display("FAIL wrap_data: got done %b data %h required 1 %h", got, wdata_o, ev); end
`endif
  endtask

  task automatic test_random();
    int lat, t0, sh; logic ps, owr, om, ost; logic [4:0] owd; logic [31:0] owdt;
    logic [3:0] op; logic [31:0] a, sd, wdat, ev; logic [4:0] wd; logic wr;
    int n, el; bit mis, st;
    for (int it = 0; it < 60; it++) begin
      op = 4'($urandom_range(0, 8)); a = 32'h1000 + 32'($urandom_range(0, 63));
      sd = $urandom; wdat = $urandom; wd = 5'($urandom_range(0, 31)); wr = 1'($urandom_range(0, 1));
      n = nb(op); mis = exp_mis(op, a); st = (n != 0) && !is_ld(op) && !mis;
      el = exp_lat(op, a); ev = exp_load(op, a);
      run_txn(op, a, sd, wd, wr, wdat, lat, t0, ps, sh, owd, owr, owdt, om, ost);
      if (st) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = sd[8*i +: 8];
      n_cmp++; if (lat != el) begin
        n_fail++; $display("FAIL rnd_lat[%0d] op %0d: got %0d required %0d", it, op, lat, el); end
      n_cmp++; if (ps !== (n != 0) || sh != ((n != 0 && !mis) ? el - 1 : 0) || ost !== 1'b0) begin
        n_fail++; $display("FAIL rnd_stall[%0d] op %0d: got pre %b high %0d done %b", it, op, ps, sh, ost); end
      n_cmp++; if (om !== mis) begin
        n_fail++; $display("FAIL rnd_mis[%0d]: got %b required %b", it, om, mis); end
      if (n == 0) begin
        n_cmp++; if (owd !== wd || owr !== wr || owdt !== wdat) begin
          n_fail++; $display("FAIL rnd_nop[%0d]: got %0d/%b/%h required %0d/%b/%h", it, owd, owr, owdt, wd, wr, wdat); end
      end else if (is_ld(op) && !mis) begin
        n_cmp++; if (owdt !== ev || owr !== (wr && wd != 5'd0) || owd !== wd) begin
          n_fail++; $display("FAIL rnd_load[%0d] op %0d @%h: got %h/%b required %h/%b", it, op, a, owdt, owr, ev, wr && wd != 5'd0); end
      end else begin
        n_cmp++; if (owr !== 1'b0 || owdt !== 32'd0) begin
          n_fail++; $display("FAIL rnd_store_wb[%0d]: got %b/%h required 0/0", it, owr, owdt); end
      end
      n_cmp++; if (wlog.size() != (st ? n : 0)) begin
        n_fail++; $display("FAIL rnd_wcount[%0d]: got %0d required %0d", it, wlog.size(), st ? n : 0); end
      for (int i = 0; i < wlog.size() && i < n; i++) begin
        n_cmp++;
        if (wlog[i].a !== a + 32'(i) || wlog[i].d !== sd[8*i +: 8] || wlog[i].c != t0 + 1 + i) begin
          n_fail++; $display("FAIL rnd_write[%0d.%0d]: got a=%h d=%h c=%0d required a=%h d=%h c=%0d",
            it, i, wlog[i].a, wlog[i].d, wlog[i].c, a + 32'(i), sd[8*i +: 8], t0 + 1 + i); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 72; i++) poke(32'h1000 + 32'(i), 8'($urandom));
    test_reset();
    test_store_sw();
    test_loads();
    test_nop();
    test_misalign();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
